alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Two-stage execute front-end: accepts decoded RV32I-style ops on a valid/ready handshake and drives operands plus the 4-bit control code into the combinational ALU.
- Captures the ALU's result and flags, resolves the branch decision, and presents a registered writeback/branch packet downstream.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous reset, active-low.
flush  in  1  synchronous; kills both stages.
in_valid  in  1  op offered.
in_ready  out  1  op accepted when in_valid && in_ready.
in_opcode  in  7  RV32I opcode.
in_funct3  in  3  funct3.
in_funct7b5  in  1  instr bit 30.
in_rs1, in_rs2, in_imm, in_pc  in  32 each  operands, sign-extended immediate, PC.
in_rd  in  5  destination register.
alu_a, alu_b  out  32 each  ALU operands, registered in S1.
alu_control  out  4  ALU op code, registered in S1.
alu_result  in  32  ALU result, combinational from alu_a/alu_b/alu_control.
alu_zero, alu_carry, alu_referee  in  1 each  ALU flags.
out_valid  out  1  packet valid.
out_ready  in  1  downstream accepts.
out_result  out  32  writeback data.
out_rd  out  5  destination register.
out_we  out  1  register-file write enable.
out_branch, out_taken  out  1 each  op is a branch / branch taken.
out_target  out  32  in_pc + in_imm, computed with a stage-local adder.
out_illegal  out  1  unsupported encoding.

Behaviour:
- Reset: every S1/S2 register is 0, including alu_a, alu_b, alu_control, out_valid and all out_* fields.
  - After reset, in_ready = 1.
- Control codes:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110.
  - AUIPC 1000 (A = pc, B = imm); LUI 1001 (B = imm).
  - SLL 1010, SRL 1011, SRA 1100.
- Decode by opcode:
  - OP 0110011: A = rs1, B = rs2; funct3 000 selects SUB if funct7b5 = 1, else ADD; funct3 101 selects SRA if funct7b5 = 1, else SRL.
  - OP-IMM 0010011: A = rs1, B = imm; funct3 000 is always ADD; 001 with funct7b5 = 1 is illegal; 101 uses funct7b5 for SRA/SRL.
  - LUI 0110111 and AUIPC 0010111 as listed above.
  - BRANCH 1100011: SUB with A = rs1, B = rs2; out_we = 0.
  - Any other opcode, and branch funct3 010 or 011, is illegal.
- Branch resolve in S2 from the ALU flags:
  - BEQ zero; BNE !zero; BLT referee; BGE !referee; BLTU !carry; BGEU carry.
- Write enable: out_we = 1 only for legal non-branch ops with rd != 0.
- Illegal packet: out_result = 0, out_we = 0, out_taken = 0, out_illegal = 1. The packet still flows with out_valid = 1.
- Pipeline control:
  - s2_load = s1_valid && (!out_valid || out_ready).
  - in_ready = !flush && (!s1_valid || s2_load).
  - S1 loads on in_valid && in_ready. S1 clears its valid on s2_load without a new accept.
  - out_valid clears on out_ready when there is no s2_load.
- Latency and throughput:
  - Op accepted at edge N appears with out_valid at edge N+1, i.e. S2 registers at the end of the following cycle.
  - Throughput is 1 op/cycle with no bubbles while out_ready = 1.
- Backpressure: while out_valid && !out_ready, every out_* field holds stable. S1 holds, and in_ready drops once S1 is occupied.
- Flush: at the next edge s1_valid = 0 and out_valid = 0; data fields need not clear.
  - flush beats in_valid and out_ready in the same cycle; no op is accepted during flush.
- Reset mid-operation: both stages empty immediately (asynchronous); in-flight ops are lost.

Test Plan:
- ADD: rs1 = 0x7FFFFFFF, rs2 = 1 -> alu_control = 0000, out_result = 0x80000000, out_we = 1.
- SUB: rs1 = 5, rs2 = 5, rd = 3 -> out_result = 0, out_we = 1.
- Branches with rs1 = 0xFFFFFFFF, rs2 = 1:
  - BLT -> out_taken = 1.
  - BLTU -> out_taken = 0.
  - BGEU -> out_taken = 1.
  - All cases: out_target = pc + imm (pc = 0x100, imm = 0xFFFFFFF0 -> 0xF0), out_we = 0.
- LUI imm = 0x12345000 -> 0x12345000. AUIPC pc = 0x1000, imm = 0x2000 -> 0x3000. OP-IMM funct3 001 with funct7b5 = 1 -> out_illegal = 1, out_we = 0.
- Backpressure:
  - Stream 4 ops while out_ready = 0 for 3 cycles -> outputs frozen, in_ready = 0 after S1 fills.
  - After release, all 4 ops emerge in order with no loss or duplication.
- Flush with both stages full, and with in_valid = 1 in the same cycle -> next cycle out_valid = 0, s1 empty, offered op not accepted. Asserting rst_n = 0 mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Two-stage execute front-end. S1 decodes an accepted op and registers the
// operands and control code that drive the external combinational ALU. S2
// captures the ALU result and flags, resolves branches, and holds the
// writeback/branch packet until the downstream side takes it.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_carry,
  input  logic            alu_referee,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_branch,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_AUIPC = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;
  localparam logic [3:0] ALU_SLL   = 4'b1010;
  localparam logic [3:0] ALU_SRL   = 4'b1011;
  localparam logic [3:0] ALU_SRA   = 4'b1100;

  // Branch condition from the flags of rs1 - rs2; carry means "no borrow".
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic carry, input logic referee);
    logic t;
    case (f3)
      3'b000:  t = zero;
      3'b001:  t = !zero;
      3'b100:  t = referee;
      3'b101:  t = !referee;
      3'b110:  t = !carry;
      3'b111:  t = carry;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Shared funct3 -> control mapping for OP and OP-IMM.
  function automatic logic [3:0] arith_ctrl(input logic [2:0] f3, input logic alt);
    logic [3:0] c;
    case (f3)
      3'b000:  c = alt ? ALU_SUB : ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = alt ? ALU_SRA : ALU_SRL;
      3'b110:  c = ALU_OR;
      3'b111:  c = ALU_AND;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  logic            s1_valid_r;
  logic [4:0]      s1_rd_r;
  logic            s1_we_r;
  logic            s1_branch_r;
  logic            s1_illegal_r;
  logic [2:0]      s1_funct3_r;
  logic [XLEN-1:0] s1_target_r;

  logic [XLEN-1:0] dec_a_s;
  logic [XLEN-1:0] dec_b_s;
  logic [3:0]      dec_ctrl_s;
  logic            dec_branch_s;
  logic            dec_illegal_s;
  logic            dec_we_s;
  logic [XLEN-1:0] dec_target_s;
  logic            s2_load_s;
  logic            accept_s;

  assign s2_load_s    = s1_valid_r && (!out_valid || out_ready);
  assign in_ready     = !flush && (!s1_valid_r || s2_load_s);
  assign accept_s     = in_valid && in_ready;
  assign dec_target_s = in_pc + in_imm;

  // Decode the offered op into ALU operands, control code and packet flags.
  always_comb begin
    dec_a_s       = in_rs1;
    dec_b_s       = in_rs2;
    dec_ctrl_s    = ALU_ADD;
    dec_branch_s  = 1'b0;
    dec_illegal_s = 1'b0;
    case (in_opcode)
      OPC_OP: begin
        dec_ctrl_s = arith_ctrl(in_funct3, in_funct7b5);
      end
      OPC_OPIMM: begin
        dec_b_s = in_imm;
        // ADDI has no subtract form, so bit 30 is ignored there.
        if (in_funct3 == 3'b000) begin
          dec_ctrl_s = ALU_ADD;
        end else begin
          dec_ctrl_s = arith_ctrl(in_funct3, in_funct7b5);
        end
        if (in_funct3 == 3'b001 && in_funct7b5) begin
          dec_illegal_s = 1'b1;
        end else begin
          dec_illegal_s = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_a_s    = {XLEN{1'b0}};
        dec_b_s    = in_imm;
        dec_ctrl_s = ALU_LUI;
      end
      OPC_AUIPC: begin
        dec_a_s    = in_pc;
        dec_b_s    = in_imm;
        dec_ctrl_s = ALU_AUIPC;
      end
      OPC_BRANCH: begin
        dec_ctrl_s = ALU_SUB;
        if (in_funct3 == 3'b010 || in_funct3 == 3'b011) begin
          dec_illegal_s = 1'b1;
        end else begin
          dec_branch_s = 1'b1;
        end
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  assign dec_we_s = !dec_illegal_s && !dec_branch_s && (in_rd != 5'd0);

  // S1: capture an accepted op, drain on handoff to S2, empty on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      alu_a        <= {XLEN{1'b0}};
      alu_b        <= {XLEN{1'b0}};
      alu_control  <= 4'd0;
      s1_rd_r      <= 5'd0;
      s1_we_r      <= 1'b0;
      s1_branch_r  <= 1'b0;
      s1_illegal_r <= 1'b0;
      s1_funct3_r  <= 3'd0;
      s1_target_r  <= {XLEN{1'b0}};
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r   <= 1'b1;
      alu_a        <= dec_a_s;
      alu_b        <= dec_b_s;
      alu_control  <= dec_ctrl_s;
      s1_rd_r      <= in_rd;
      s1_we_r      <= dec_we_s;
      s1_branch_r  <= dec_branch_s;
      s1_illegal_r <= dec_illegal_s;
      s1_funct3_r  <= in_funct3;
      s1_target_r  <= dec_target_s;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // S2: capture ALU result and resolve the branch; hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_result  <= {XLEN{1'b0}};
      out_rd      <= 5'd0;
      out_we      <= 1'b0;
      out_branch  <= 1'b0;
      out_taken   <= 1'b0;
      out_target  <= {XLEN{1'b0}};
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load_s) begin
      out_valid   <= 1'b1;
      out_result  <= s1_illegal_r ? {XLEN{1'b0}} : alu_result;
      out_rd      <= s1_rd_r;
      out_we      <= s1_we_r;
      out_branch  <= s1_branch_r;
      out_taken   <= s1_branch_r &&
                     branch_taken(s1_funct3_r, alu_zero, alu_carry, alu_referee);
      out_target  <= s1_target_r;
      out_illegal <= s1_illegal_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU on the side.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [4:0]  in_rd;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_control;
  logic        alu_zero, alu_carry, alu_referee;
  logic        out_valid, out_ready, out_we, out_branch, out_taken, out_illegal;
  logic [31:0] out_result, out_target;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_referee(alu_referee),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .out_branch(out_branch),
    .out_taken(out_taken), .out_target(out_target), .out_illegal(out_illegal)
  );

  // Reference combinational ALU; carry = no borrow on a - b, referee = signed a < b.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a ^ alu_b;
      4'b0101: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0110: alu_result = {31'd0, alu_a < alu_b};
      4'b1000: alu_result = alu_a + alu_b;
      4'b1001: alu_result = alu_b;
      4'b1010: alu_result = alu_a << alu_b[4:0];
      4'b1011: alu_result = alu_a >> alu_b[4:0];
      4'b1100: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = 32'd0;
    endcase
    alu_zero    = (alu_result == 32'd0);
    alu_carry   = (alu_a >= alu_b);
    alu_referee = ($signed(alu_a) < $signed(alu_b));
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    in_opcode = op; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
    in_valid = 1'b1;
  endtask

  // Offer one op for a single cycle; on return the op sits in S1.
  task automatic send_one(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
    @(negedge clk);
    drive(op, f3, f7, rs1, rs2, imm, pc, rd);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (alu_control !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL reset_alu got %h %h %h exp 0", alu_control, alu_a, alu_b); end
    checks++; if (out_result !== 32'd0 || out_rd !== 5'd0 || out_target !== 32'd0) begin errors++; $display("FAIL reset_out_fields got %h %h %h exp 0", out_result, out_rd, out_target); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add_sub();
    send_one(7'b0110011, 3'b000, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0, 5'd5);
    checks++; if (alu_control !== 4'b0000 || alu_a !== 32'h7FFFFFFF || alu_b !== 32'd1) begin errors++; $display("FAIL add_s1 got ctrl %h a %h b %h exp 0 7fffffff 1", alu_control, alu_a, alu_b); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h80000000 || out_we !== 1'b1 || out_rd !== 5'd5) begin errors++; $display("FAIL add_out got v %b res %h we %b rd %0d exp 1 80000000 1 5", out_valid, out_result, out_we, out_rd); end
    send_one(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd5, 32'd0, 32'd0, 5'd3);
    checks++; if (alu_control !== 4'b0001) begin errors++; $display("FAIL sub_ctrl got %h exp 1", alu_control); end
    @(negedge clk);
    checks++; if (out_result !== 32'd0 || out_we !== 1'b1 || out_rd !== 5'd3 || out_illegal !== 1'b0) begin errors++; $display("FAIL sub_out got res %h we %b rd %0d ill %b exp 0 1 3 0", out_result, out_we, out_rd, out_illegal); end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [3];
    logic       exp_taken [3];
    f3s[0] = 3'b100; exp_taken[0] = 1'b1;
    f3s[1] = 3'b110; exp_taken[1] = 1'b0;
    f3s[2] = 3'b111; exp_taken[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_one(7'b1100011, f3s[i], 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 32'h100, 5'd9);
      @(negedge clk);
      checks++; if (out_taken !== exp_taken[i] || out_branch !== 1'b1) begin errors++; $display("FAIL branch_taken f3 %b got taken %b br %b exp %b 1", f3s[i], out_taken, out_branch, exp_taken[i]); end
      checks++; if (out_target !== 32'hF0 || out_we !== 1'b0) begin errors++; $display("FAIL branch_target f3 %b got tgt %h we %b exp f0 0", f3s[i], out_target, out_we); end
    end
  endtask

  task automatic test_upper_and_illegal();
    send_one(7'b0110111, 3'b000, 1'b0, 32'hDEADBEEF, 32'd0, 32'h12345000, 32'd0, 5'd4);
    checks++; if (alu_control !== 4'b1001) begin errors++; $display("FAIL lui_ctrl got %h exp 9", alu_control); end
    @(negedge clk);
    checks++; if (out_result !== 32'h12345000 || out_we !== 1'b1) begin errors++; $display("FAIL lui_out got %h we %b exp 12345000 1", out_result, out_we); end
    send_one(7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h2000, 32'h1000, 5'd6);
    @(negedge clk);
    checks++; if (out_result !== 32'h3000 || out_we !== 1'b1) begin errors++; $display("FAIL auipc_out got %h we %b exp 3000 1", out_result, out_we); end
    send_one(7'b0010011, 3'b001, 1'b1, 32'd7, 32'd0, 32'd3, 32'd0, 5'd8);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_we !== 1'b0 || out_result !== 32'd0 || out_taken !== 1'b0) begin errors++; $display("FAIL opimm_illegal got v %b ill %b we %b res %h tk %b exp 1 1 0 0 0", out_valid, out_illegal, out_we, out_result, out_taken); end
    send_one(7'b0010011, 3'b001, 1'b0, 32'd3, 32'd0, 32'd4, 32'd0, 5'd8);
    @(negedge clk);
    checks++; if (out_illegal !== 1'b0 || out_result !== 32'h30) begin errors++; $display("FAIL slli_out got ill %b res %h exp 0 30", out_illegal, out_result); end
    send_one(7'b0000011, 3'b010, 1'b0, 32'd3, 32'd0, 32'd4, 32'd0, 5'd8);
    @(negedge clk);
    checks++; if (out_illegal !== 1'b1 || out_we !== 1'b0) begin errors++; $display("FAIL opcode_illegal got ill %b we %b exp 1 0", out_illegal, out_we); end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int recv = 0;
    int first = -1;
    int last = -1;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (k < 4) drive(7'b0110011, 3'b000, 1'b0, 32'h100 + k, 32'h10, 32'd0, 32'd0, 5'(k + 1));
      else in_valid = 1'b0;
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h110 || out_rd !== 5'd1) begin errors++; $display("FAIL bp_stall cyc %0d got rdy %b v %b res %h rd %0d exp 0 1 110 1", cyc, in_ready, out_valid, out_result, out_rd); end
      end
      if (out_valid && out_ready) begin
        checks++; if (out_result !== 32'h110 + recv || out_rd !== 5'(recv + 1)) begin errors++; $display("FAIL bp_order idx %0d got res %h rd %0d exp %h %0d", recv, out_result, out_rd, 32'h110 + recv, recv + 1); end
        if (first < 0) first = cyc;
        last = cyc;
        recv++;
      end
      if (in_valid && in_ready) k++;
    end
    in_valid = 1'b0;
    checks++; if (recv != 4 || last - first != 3) begin errors++; $display("FAIL bp_count got %0d ops over %0d cycles exp 4 over 3", recv, last - first); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got out_valid %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0;
    drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1);
    @(negedge clk);
    drive(7'b0110011, 3'b000, 1'b0, 32'd2, 32'd2, 32'd0, 32'd0, 5'd2);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd2) begin errors++; $display("FAIL flush_pre got v %b res %h exp 1 2", out_valid, out_result); end
    flush = 1'b1; out_ready = 1'b1;
    drive(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 5'd3);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_s1_empty got out_valid %b res %h exp 0", out_valid, out_result); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    @(negedge clk);
    drive(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'h40, 32'h80, 5'd7);
    @(negedge clk);
    drive(7'b0110011, 3'b100, 1'b0, 32'd6, 32'd3, 32'h40, 32'h80, 5'd7);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd3) begin errors++; $display("FAIL rstmid_pre got v %b res %h exp 1 3", out_valid, out_result); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd !== 5'd0 || out_target !== 32'd0) begin errors++; $display("FAIL rstmid_out got v %b res %h rd %0d tgt %h exp 0", out_valid, out_result, out_rd, out_target); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 4'd0) begin errors++; $display("FAIL rstmid_alu got %h %h %h exp 0", alu_a, alu_b, alu_control); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after got v %b rdy %b exp 0 1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_branch();
    test_upper_and_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
